// File: rtl/train_step_control.sv
`default_nettype none
// ============================================================================
// Module      : train_step_control
// Description : Central sequencer for one training run. For each sample it
//               handshakes the input in, enables the forward net for its
//               fixed latency, walks the backward net layer by layer with a
//               per-layer da sample strobe, then accumulates gradients. After
//               batch_size samples it issues one weight update, and it repeats
//               this for num_batches batches.
// Ports       : clk, reset (async, active-high)
//               start, abort                  - run control
//               batch_size, num_batches       - run config, latched on start
//               sample_valid / sample_ready   - sample input handshake
//               fwd_enable, bwd_enable, bwd_sample, layer_idx
//                                             - forward/backward net control
//               acc_enable, acc_clear, update_enable
//                                             - gradient datapath control
//               sample_count, batch_count     - progress counters
//               busy, done                    - status
// Revision    : 1.0 - initial release
// ============================================================================
module train_step_control #(
    parameter int FWD_LAT  = 16,
    parameter int BWD_LAT  = 9,
    parameter int N_LAYERS = 3,
    parameter int BATCH_W  = 8,
    parameter int NB_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [BATCH_W-1:0] batch_size,
    input  logic [NB_W-1:0]    num_batches,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               fwd_enable,
    output logic               bwd_enable,
    output logic               bwd_sample,
    output logic [1:0]         layer_idx,
    output logic               acc_enable,
    output logic               acc_clear,
    output logic               update_enable,
    output logic [BATCH_W-1:0] sample_count,
    output logic [NB_W-1:0]    batch_count,
    output logic               busy,
    output logic               done
);

    // Phase counter is shared between the forward window and each backward
    // layer window, so it is sized for the longer of the two.
    localparam int CNT_MAX = (FWD_LAT > BWD_LAT) ? FWD_LAT : BWD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_FWD    = 3'd3;
    localparam logic [2:0] S_BWD    = 3'd4;
    localparam logic [2:0] S_ACC    = 3'd5;
    localparam logic [2:0] S_UPDATE = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_layer;
    logic [BATCH_W-1:0] r_sample_count;
    logic [NB_W-1:0]    r_batch_count;
    logic [BATCH_W-1:0] r_bs_eff;
    logic [NB_W-1:0]    r_nb;

    logic w_fwd_last;
    logic w_win_last;
    logic w_layer_last;
    logic w_batch_last;
    logic w_run_last;
    logic w_run_start;

    assign w_fwd_last   = (r_cnt == CNT_W'(FWD_LAT - 1));
    assign w_win_last   = (r_cnt == CNT_W'(BWD_LAT - 1));
    assign w_layer_last = (r_layer == 2'(N_LAYERS - 1));
    assign w_batch_last = ((r_sample_count + BATCH_W'(1)) == r_bs_eff);
    assign w_run_last   = ((r_batch_count + NB_W'(1)) == r_nb);
    // abort beats start even in IDLE, so a simultaneous pair does nothing.
    assign w_run_start  = (r_state == S_IDLE) && start && !abort;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_run_start) begin
                    w_next_state = (num_batches == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR:  w_next_state = S_LOAD;
            S_LOAD: begin
                if (sample_valid) w_next_state = S_FWD;
            end
            S_FWD: begin
                if (w_fwd_last) w_next_state = S_BWD;
            end
            S_BWD: begin
                if (w_win_last && w_layer_last) w_next_state = S_ACC;
            end
            S_ACC:    w_next_state = w_batch_last ? S_UPDATE : S_LOAD;
            S_UPDATE: w_next_state = w_run_last ? S_DONE : S_CLEAR;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Phase / layer counters, progress counters and latched config
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_layer        <= '0;
            r_sample_count <= '0;
            r_batch_count  <= '0;
            r_bs_eff       <= '0;
            r_nb           <= '0;
        end else begin
            // Phase counter runs only inside a window and wraps at its end;
            // everywhere else it idles at zero so each window starts clean.
            if (!abort && (((r_state == S_FWD) && !w_fwd_last) ||
                           ((r_state == S_BWD) && !w_win_last))) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            // Layer counter replaces cnt / BWD_LAT over the backward phase.
            if (r_state != S_BWD || abort) begin
                r_layer <= '0;
            end else if (w_win_last) begin
                r_layer <= w_layer_last ? 2'd0 : r_layer + 2'd1;
            end

            if (w_run_start) begin
                r_sample_count <= '0;
                r_batch_count  <= '0;
                r_bs_eff       <= (batch_size == '0) ? BATCH_W'(1) : batch_size;
                r_nb           <= num_batches;
            end else if (!abort) begin
                // On abort the progress counters hold for debug.
                if (r_state == S_CLEAR) begin
                    r_sample_count <= '0;
                end else if (r_state == S_ACC) begin
                    r_sample_count <= r_sample_count + BATCH_W'(1);
                end
                if (r_state == S_UPDATE) begin
                    r_batch_count <= r_batch_count + NB_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        sample_ready  = 1'b0;
        fwd_enable    = 1'b0;
        bwd_enable    = 1'b0;
        bwd_sample    = 1'b0;
        layer_idx     = 2'd0;
        acc_enable    = 1'b0;
        acc_clear     = 1'b0;
        update_enable = 1'b0;
        done          = 1'b0;
        busy          = (r_state != S_IDLE);
        case (r_state)
            S_CLEAR:  acc_clear     = 1'b1;
            S_LOAD:   sample_ready  = 1'b1;
            S_FWD:    fwd_enable    = 1'b1;
            S_BWD: begin
                bwd_enable = 1'b1;
                bwd_sample = w_win_last;
                layer_idx  = r_layer;
            end
            S_ACC:    acc_enable    = 1'b1;
            S_UPDATE: update_enable = 1'b1;
            S_DONE:   done          = 1'b1;
            default: ;
        endcase
    end

    assign sample_count = r_sample_count;
    assign batch_count  = r_batch_count;

endmodule
`default_nettype wire
